fir_level_detector: RTL

- Sits directly downstream of the 27-tap symmetric FIR low-pass filter (12-bit signed samples, one per clock at 50 MHz).
- Converts the filtered waveform into a debounced binary level using programmable hysteresis thresholds.
- Emits rise/fall pulses and measures each high-interval width in clock cycles for the register/control logic.

---
 rtl/fir_pkg.sv | 29 ++
 rtl/fir_level_detector_pulse_width_meter.sv | 81 ++++++++
 rtl/fir_level_detector.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/fir_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package     : fir_pkg                                                |
// | Description : Shared types and constants for the FIR back-end level  |
// |               detector (sample width, FSM states, default thresholds)|
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package fir_pkg;

  localparam int FIR_DATA_W = 12;
  localparam int FIR_DEB_W  = 8;  // debounce counter, covers 1..255

  localparam logic signed [FIR_DATA_W-1:0] FIR_TH_HI_RST = 12'sd512;
  localparam logic signed [FIR_DATA_W-1:0] FIR_TH_LO_RST = 12'sd256;

  typedef enum logic [1:0] {
    LOW       = 2'd0,
    RISE_PEND = 2'd1,
    HIGH      = 2'd2,
    FALL_PEND = 2'd3
  } lvl_state_e;

  // The debounced level is high in HIGH and while a fall is still pending.
  function automatic logic state_is_high(input lvl_state_e st);
    return (st == HIGH) || (st == FALL_PEND);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fir_level_detector_pulse_width_meter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : pulse_width_meter                                      |
// | Description : Saturating high-interval counter. Counts cycles while  |
// |               level is high and latches the count on the fall cycle. |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module pulse_width_meter #(
  parameter int WIDTH_W = 24
) (
  input  logic               i_fpga_clk,
  input  logic               i_rst_n,
  input  logic               clear_i,   // detector disabled: drop the interval
  input  logic               level_i,   // next-cycle level
  input  logic               rise_i,    // next-cycle rise pulse
  input  logic               fall_i,    // next-cycle fall pulse
  output logic [WIDTH_W-1:0] width_o,
  output logic               width_valid_o,
  output logic               width_sat_o
);

  localparam logic [WIDTH_W-1:0] c_CNT_MAX = '1;

  logic [WIDTH_W-1:0] cnt_q,   cnt_d;
  logic               sat_q,   sat_d;
  logic [WIDTH_W-1:0] width_q, width_d;
  logic               valid_q, valid_d;
  logic               wsat_q,  wsat_d;

  // Counter runs in step with the level register, so on the fall cycle it
  // already holds the number of cycles the level was high.
  always_comb begin
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    width_d = width_q;
    valid_d = 1'b0;
    wsat_d  = wsat_q;
    if (clear_i) begin
      cnt_d = '0;
      sat_d = 1'b0;
    end else if (rise_i) begin
      cnt_d = {{(WIDTH_W-1){1'b0}}, 1'b1};
      sat_d = 1'b0;
    end else if (fall_i) begin
      width_d = cnt_q;
      valid_d = 1'b1;
      wsat_d  = sat_q;
      cnt_d   = '0;
      sat_d   = 1'b0;
    end else if (level_i) begin
      if (cnt_q == c_CNT_MAX) begin
        sat_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Meter state registers.
  always_ff @(posedge i_fpga_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q   <= '0;
      sat_q   <= 1'b0;
      width_q <= '0;
      valid_q <= 1'b0;
      wsat_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
      width_q <= width_d;
      valid_q <= valid_d;
      wsat_q  <= wsat_d;
    end
  end

  assign width_o       = width_q;
  assign width_valid_o = valid_q;
  assign width_sat_o   = wsat_q;

endmodule
`default_nettype wire

// File: rtl/fir_level_detector.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : fir_level_detector                                     |
// | Description : Debounced hysteresis level detector for the FIR output |
// |               with rise/fall pulses and high-interval width meter.   |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module fir_level_detector
  import fir_pkg::*;
#(
  parameter int                       DATA_W    = FIR_DATA_W,
  parameter int                       DEBOUNCE  = 4,
  parameter int                       WIDTH_W   = 24,
  parameter logic signed [DATA_W-1:0] TH_HI_RST = FIR_TH_HI_RST,
  parameter logic signed [DATA_W-1:0] TH_LO_RST = FIR_TH_LO_RST
) (
  input  logic                     i_fpga_clk,
  input  logic                     i_rst_n,
  input  logic                     i_enable,
  input  logic signed [DATA_W-1:0] i_filter_in,
  input  logic                     i_cfg_wr,
  input  logic signed [DATA_W-1:0] i_th_hi,
  input  logic signed [DATA_W-1:0] i_th_lo,
  output logic                     o_level,
  output logic                     o_rise,
  output logic                     o_fall,
  output logic [WIDTH_W-1:0]       o_width,
  output logic                     o_width_valid,
  output logic                     o_width_sat
);

  logic signed [DATA_W-1:0] x_q;
  logic signed [DATA_W-1:0] th_hi_q;
  logic signed [DATA_W-1:0] th_lo_q;
  lvl_state_e               state_q, state_d;
  logic [FIR_DEB_W-1:0]     deb_q,   deb_d;
  logic                     level_q, level_d;
  logic                     rise_q,  rise_d;
  logic                     fall_q,  fall_d;

  logic                     w_above;
  logic                     w_below;
  logic                     w_deb_done;
  logic signed [DATA_W-1:0] w_lo_load;

  assign w_above    = (x_q >= th_hi_q);
  assign w_below    = (x_q <= th_lo_q);
  assign w_deb_done = (({1'b0, deb_q} + 9'd1) == 9'(DEBOUNCE));
  // An inverted pair is clamped to zero hysteresis.
  assign w_lo_load  = (i_th_lo > i_th_hi) ? i_th_hi : i_th_lo;

  // Input sample register and threshold registers.
  always_ff @(posedge i_fpga_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      x_q     <= '0;
      th_hi_q <= TH_HI_RST;
      th_lo_q <= TH_LO_RST;
    end else begin
      x_q <= i_filter_in;
      if (i_cfg_wr) begin
        th_hi_q <= i_th_hi;
        th_lo_q <= w_lo_load;
      end
    end
  end

  // FSM and output pulse registers.
  always_ff @(posedge i_fpga_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= LOW;
      deb_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      deb_q   <= deb_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  // Next state: disable beats a config write, which beats any transition.
  always_comb begin
    state_d = state_q;
    deb_d   = deb_q;
    if (!i_enable) begin
      state_d = LOW;
      deb_d   = '0;
    end else if (i_cfg_wr) begin
      deb_d = '0;
      if (state_q == RISE_PEND) state_d = LOW;
      if (state_q == FALL_PEND) state_d = HIGH;
    end else begin
      case (state_q)
        LOW: begin
          if (w_above) begin
            if (DEBOUNCE == 1) begin
              state_d = HIGH;
              deb_d   = '0;
            end else begin
              state_d = RISE_PEND;
              deb_d   = 8'd1;
            end
          end
        end
        RISE_PEND: begin
          if (!w_above) begin
            state_d = LOW;
            deb_d   = '0;
          end else if (w_deb_done) begin
            state_d = HIGH;
            deb_d   = '0;
          end else begin
            deb_d = deb_q + 8'd1;
          end
        end
        HIGH: begin
          if (w_below) begin
            if (DEBOUNCE == 1) begin
              state_d = LOW;
              deb_d   = '0;
            end else begin
              state_d = FALL_PEND;
              deb_d   = 8'd1;
            end
          end
        end
        default: begin
          if (!w_below) begin
            state_d = HIGH;
            deb_d   = '0;
          end else if (w_deb_done) begin
            state_d = LOW;
            deb_d   = '0;
          end else begin
            deb_d = deb_q + 8'd1;
          end
        end
      endcase
    end
  end

  // Level follows the settled state one cycle later; disabling drops it
  // immediately and silently.
  always_comb begin
    level_d = i_enable & state_is_high(state_q);
    rise_d  = level_d & ~level_q;
    fall_d  = i_enable & level_q & ~level_d;
  end

  pulse_width_meter #(
    .WIDTH_W (WIDTH_W)
  ) u_meter (
    .i_fpga_clk    (i_fpga_clk),
    .i_rst_n       (i_rst_n),
    .clear_i       (~i_enable),
    .level_i       (level_d),
    .rise_i        (rise_d),
    .fall_i        (fall_d),
    .width_o       (o_width),
    .width_valid_o (o_width_valid),
    .width_sat_o   (o_width_sat)
  );

  assign o_level = level_q;
  assign o_rise  = rise_q;
  assign o_fall  = fall_q;

endmodule
`default_nettype wire
